// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, drives program memory and hands fetched words to decode.
// Redirects come from execute (jump/call) and from a small circular return-address stack.
module fetch_unit #(
  parameter int ADDR_W   = 8,
  parameter int INS_W    = 20,
  parameter int RS_DEPTH = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              stall,
  input  logic              stall_pm,
  input  logic [INS_W-1:0]  ins_pm,
  input  logic              jump_en,
  input  logic [ADDR_W-1:0] jmp_loc,
  input  logic              call_en,
  input  logic [ADDR_W-1:0] push_addr,
  input  logic              ret_en,
  output logic [ADDR_W-1:0] pm_addr,
  output logic [INS_W-1:0]  ins,
  output logic [ADDR_W-1:0] ins_addr,
  output logic              rs_empty,
  output logic              rs_full,
  output logic              rs_err
);

  localparam int TP_W = $clog2(RS_DEPTH);
  localparam int SP_W = TP_W + 1;

  logic [ADDR_W-1:0] pc_reg, pc_next;
  logic [ADDR_W-1:0] ins_addr_reg;
  logic [SP_W-1:0]   sp_reg, sp_next;
  logic [TP_W-1:0]   tp_reg, tp_next;
  logic              rs_err_reg, rs_err_next;
  logic [ADDR_W-1:0] rs_mem [RS_DEPTH];
  logic [TP_W-1:0]   top_idx;
  logic [TP_W-1:0]   rs_widx;
  logic              rs_we;
  logic [ADDR_W-1:0] pop_addr;
  logic [RS_DEPTH-1:0] entry_we;

  // tp_reg is the next free slot; it wraps so a push on a full stack overwrites the oldest entry
  assign top_idx  = tp_reg - TP_W'(1);
  assign rs_empty = (sp_reg == '0);
  assign rs_full  = (sp_reg == SP_W'(RS_DEPTH));
  assign pop_addr = rs_empty ? '0 : rs_mem[top_idx];

  always_comb begin
    sp_next     = sp_reg;
    tp_next     = tp_reg;
    rs_err_next = rs_err_reg;
    rs_we       = 1'b0;
    rs_widx     = tp_reg;
    if (call_en && ret_en) begin
      rs_we   = 1'b1;
      rs_widx = top_idx;
      if (rs_empty) rs_err_next = 1'b1;
    end else if (call_en) begin
      rs_we   = 1'b1;
      tp_next = tp_reg + TP_W'(1);
      if (rs_full) rs_err_next = 1'b1;
      else         sp_next     = sp_reg + SP_W'(1);
    end else if (ret_en) begin
      if (rs_empty) begin
        rs_err_next = 1'b1;
      end else begin
        tp_next = top_idx;
        sp_next = sp_reg - SP_W'(1);
      end
    end
  end

  always_comb begin
    pc_next = pc_reg + ADDR_W'(1);
    if (ret_en)       pc_next = pop_addr;
    else if (jump_en) pc_next = jmp_loc;
    else if (stall)   pc_next = pc_reg;
  end

  generate
    for (genvar gi = 0; gi < RS_DEPTH; gi++) begin : g_entry_we
      assign entry_we[gi] = rs_we && (rs_widx == TP_W'(gi));
    end
  endgenerate

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < RS_DEPTH; i++) rs_mem[i] <= '0;
    end else begin
      for (int i = 0; i < RS_DEPTH; i++)
        if (entry_we[i]) rs_mem[i] <= push_addr;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc_reg       <= '0;
      ins_addr_reg <= '0;
      sp_reg       <= '0;
      tp_reg       <= '0;
      rs_err_reg   <= 1'b0;
    end else begin
      pc_reg       <= pc_next;
      ins_addr_reg <= pc_reg;
      sp_reg       <= sp_next;
      tp_reg       <= tp_next;
      rs_err_reg   <= rs_err_next;
    end
  end

  assign pm_addr  = pc_reg;
  assign ins_addr = ins_addr_reg;
  assign rs_err   = rs_err_reg;
  // Bubble is injected combinationally so decode never sees a stale word while reset or stall_pm is active
  assign ins      = (stall_pm || !reset) ? '0 : ins_pm;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: a vector table walked cycle by cycle against a synchronous memory model,
// plus a hand-written asynchronous-reset sequence.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        stall, stall_pm, jump_en, call_en, ret_en;
  logic [19:0] ins_pm;
  logic [7:0]  jmp_loc, push_addr;
  logic [7:0]  pm_addr, ins_addr;
  logic [19:0] ins;
  logic        rs_empty, rs_full, rs_err;

  int n_pass = 0;
  int n_checks = 0;

  fetch_unit #(.ADDR_W(8), .INS_W(20), .RS_DEPTH(4)) dut (
    .clk(clk), .reset(reset), .stall(stall), .stall_pm(stall_pm), .ins_pm(ins_pm),
    .jump_en(jump_en), .jmp_loc(jmp_loc), .call_en(call_en), .push_addr(push_addr),
    .ret_en(ret_en), .pm_addr(pm_addr), .ins(ins), .ins_addr(ins_addr),
    .rs_empty(rs_empty), .rs_full(rs_full), .rs_err(rs_err)
  );

  always #5 clk = ~clk;

  function automatic logic [19:0] memv(input logic [7:0] a);
    return {12'hABC, a};
  endfunction

  // Program memory: one-cycle registered read
  always @(posedge clk) ins_pm <= memv(pm_addr);

  typedef struct {
    logic st, spm, je, ce, re;
    logic [7:0] jl, pa;
    logic [7:0] e_pm, e_ia;
    logic [19:0] e_ins;
    logic e_emp, e_full, e_err;
  } vec_t;

  vec_t vecs[$];

  task automatic row(input logic st, spm, je, input logic [7:0] jl, input logic ce,
                     input logic [7:0] pa, input logic re, input logic [7:0] epm, eia,
                     input logic emp, full, err);
    vec_t v;
    v.st = st; v.spm = spm; v.je = je; v.jl = jl; v.ce = ce; v.pa = pa; v.re = re;
    v.e_pm = epm; v.e_ia = eia; v.e_ins = spm ? 20'h0 : memv(eia);
    v.e_emp = emp; v.e_full = full; v.e_err = err;
    vecs.push_back(v);
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  task automatic idle_inputs();
    stall = 0; stall_pm = 0; jump_en = 0; call_en = 0; ret_en = 0; jmp_loc = 0; push_addr = 0;
  endtask

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: time limit reached");
    $display("%0d/%0d checks passed", n_pass, n_checks + 1);
    $fatal(1, "timeout");
  end

  initial begin
    idle_inputs();
    reset = 0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_pm", pm_addr, 8'h00);
    chk("reset_ins", ins, 20'h0);
    chk("reset_empty", rs_empty, 1'b1);
    chk("reset_full", rs_full, 1'b0);
    chk("reset_err", rs_err, 1'b0);
    reset = 1;
    #1;
    chk("rel_ins", ins, memv(8'h00));
    chk("rel_ia", ins_addr, 8'h00);

    //   st spm je jl     ce pa     re  pm     ia     emp full err
    row(0, 0, 0, 8'h00, 0, 8'h00, 0, 8'h01, 8'h00, 1, 0, 0);
    row(0, 0, 0, 8'h00, 0, 8'h00, 0, 8'h02, 8'h01, 1, 0, 0);
    row(0, 0, 0, 8'h00, 0, 8'h00, 0, 8'h03, 8'h02, 1, 0, 0);
    row(0, 0, 1, 8'h10, 0, 8'h00, 0, 8'h10, 8'h03, 1, 0, 0);
    row(1, 0, 0, 8'h00, 0, 8'h00, 0, 8'h10, 8'h10, 1, 0, 0);
    row(1, 1, 0, 8'h00, 0, 8'h00, 0, 8'h10, 8'h10, 1, 0, 0);
    row(0, 1, 0, 8'h00, 0, 8'h00, 0, 8'h11, 8'h10, 1, 0, 0);
    row(0, 0, 0, 8'h00, 0, 8'h00, 0, 8'h12, 8'h11, 1, 0, 0);
    row(0, 0, 1, 8'h40, 1, 8'h06, 0, 8'h40, 8'h12, 0, 0, 0);
    row(0, 0, 0, 8'h00, 0, 8'h00, 0, 8'h41, 8'h40, 0, 0, 0);
    row(0, 0, 0, 8'h00, 0, 8'h00, 0, 8'h42, 8'h41, 0, 0, 0);
    row(0, 0, 0, 8'h00, 0, 8'h00, 1, 8'h06, 8'h42, 1, 0, 0);
    row(0, 0, 0, 8'h00, 0, 8'h00, 0, 8'h07, 8'h06, 1, 0, 0);
    row(0, 0, 0, 8'h00, 1, 8'hA1, 0, 8'h08, 8'h07, 0, 0, 0);
    row(0, 0, 0, 8'h00, 1, 8'hA2, 0, 8'h09, 8'h08, 0, 0, 0);
    row(0, 0, 0, 8'h00, 1, 8'hA3, 0, 8'h0A, 8'h09, 0, 0, 0);
    row(0, 0, 0, 8'h00, 1, 8'hA4, 0, 8'h0B, 8'h0A, 0, 1, 0);
    row(0, 0, 0, 8'h00, 1, 8'hA5, 0, 8'h0C, 8'h0B, 0, 1, 1);
    row(0, 0, 0, 8'h00, 0, 8'h00, 1, 8'hA5, 8'h0C, 0, 0, 1);
    row(0, 0, 0, 8'h00, 0, 8'h00, 1, 8'hA4, 8'hA5, 0, 0, 1);
    row(0, 0, 0, 8'h00, 0, 8'h00, 1, 8'hA3, 8'hA4, 0, 0, 1);
    row(0, 0, 0, 8'h00, 0, 8'h00, 1, 8'hA2, 8'hA3, 1, 0, 1);
    row(0, 0, 0, 8'h00, 0, 8'h00, 1, 8'h00, 8'hA2, 1, 0, 1);
    row(0, 0, 0, 8'h00, 0, 8'h00, 0, 8'h01, 8'h00, 1, 0, 1);
    row(0, 0, 0, 8'h00, 1, 8'hB0, 0, 8'h02, 8'h01, 0, 0, 1);
    row(0, 0, 0, 8'h00, 1, 8'hC5, 1, 8'hB0, 8'h02, 0, 0, 1);
    row(0, 0, 0, 8'h00, 0, 8'h00, 1, 8'hC5, 8'hB0, 1, 0, 1);
    row(0, 0, 0, 8'h00, 0, 8'h00, 0, 8'hC6, 8'hC5, 1, 0, 1);
    row(0, 0, 0, 8'h00, 1, 8'h33, 0, 8'hC7, 8'hC6, 0, 0, 1);
    row(0, 0, 1, 8'h77, 0, 8'h00, 1, 8'h33, 8'hC7, 1, 0, 1);
    row(1, 0, 1, 8'hFE, 0, 8'h00, 0, 8'hFE, 8'h33, 1, 0, 1);
    row(0, 0, 0, 8'h00, 0, 8'h00, 0, 8'hFF, 8'hFE, 1, 0, 1);
    row(0, 0, 0, 8'h00, 0, 8'h00, 0, 8'h00, 8'hFF, 1, 0, 1);
    row(0, 0, 0, 8'h00, 0, 8'h00, 0, 8'h01, 8'h00, 1, 0, 1);

    foreach (vecs[k]) begin
      stall = vecs[k].st; stall_pm = vecs[k].spm; jump_en = vecs[k].je; jmp_loc = vecs[k].jl;
      call_en = vecs[k].ce; push_addr = vecs[k].pa; ret_en = vecs[k].re;
      @(posedge clk);
      #1;
      chk($sformatf("v%0d_pm", k), pm_addr, vecs[k].e_pm);
      chk($sformatf("v%0d_ia", k), ins_addr, vecs[k].e_ia);
      chk($sformatf("v%0d_ins", k), ins, vecs[k].e_ins);
      chk($sformatf("v%0d_flags", k), {rs_empty, rs_full, rs_err},
          {vecs[k].e_emp, vecs[k].e_full, vecs[k].e_err});
      $display("vec %0d: pm=%02h ia=%02h ins=%05h emp=%0b full=%0b err=%0b",
               k, pm_addr, ins_addr, ins, rs_empty, rs_full, rs_err);
    end

    // Asynchronous reset in the same cycle as a taken jump, with a live stack entry
    idle_inputs();
    call_en = 1; push_addr = 8'h5A;
    @(posedge clk);
    #1;
    call_en = 0;
    jump_en = 1; jmp_loc = 8'h55;
    #2;
    reset = 0;
    #1;
    chk("async_pm", pm_addr, 8'h00);
    chk("async_ia", ins_addr, 8'h00);
    chk("async_ins", ins, 20'h0);
    chk("async_empty", rs_empty, 1'b1);
    chk("async_err", rs_err, 1'b0);
    $display("async reset: pm=%02h ins=%05h emp=%0b err=%0b", pm_addr, ins, rs_empty, rs_err);
    @(posedge clk);
    #1;
    jump_en = 0;
    chk("held_pm", pm_addr, 8'h00);
    @(posedge clk);
    #1;
    reset = 1;
    @(posedge clk);
    #1;
    chk("post_rel_pm", pm_addr, 8'h01);
    chk("post_rel_ins", ins, memv(8'h00));
    // Popping must find an empty stack: the pre-reset push was discarded
    ret_en = 1;
    @(posedge clk);
    #1;
    ret_en = 0;
    chk("post_rel_pop", pm_addr, 8'h00);
    chk("post_rel_err", rs_err, 1'b1);
    $display("post reset pop: pm=%02h err=%0b", pm_addr, rs_err);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
